encoder4to2_queue: RTL and testbench
====================================

# encoder4to2_queue

Registered 4-to-2 priority encoder with request queueing and a valid/ack output handshake; it is the encoding counterpart of the team's 2-to-4 decoder. Four request lines D0..D3 set per-line pending bits, and the block presents one granted index at a time as the code A1/A0. A downstream consumer retires each code with ack. The block flags same-cycle collisions and reports queue depth. It sits between request sources and any logic that consumes a 2-bit index, for example a decoder2to4 fed back to select a target.

## Interface
- ERR_STICKY, default 1: 1 = collision flag `multi` holds until `err_clr`; 0 = `multi` is a one-cycle pulse.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- D0, D1, D2, D3  in  1 each  request lines, sampled every rising edge
- ack  in  1  consumer accepts the presented code; ignored when valid=0
- err_clr  in  1  clears sticky `multi`
- A1, A0  out  1 each  encoded index of the presented request (A1 is MSB)
- valid  out  1  A1/A0 hold a live code
- pend_cnt  out  3  popcount of waiting (not yet presented) requests, 0..4
- multi  out  1  collision flag: more than one D line high in the same cycle

## Operation
- State: pending register P[3:0], output register {A1,A0}, valid, multi, pend_cnt, and last[1:0] (the last granted index, used only with ENC_RR_EN).
- Per edge, let Dv = {D3,D2,D1,D0} and nxt = P | Dv.
- Load condition is (!valid || ack) && nxt != 0:
  - sel = select(nxt)
  - {A1,A0} <= sel, valid <= 1
  - P <= nxt & ~onehot(sel)
  - last <= sel
- Hold condition is valid && !ack:
  - P <= nxt
  - A1/A0 and valid are unchanged.
- Drain condition is (!valid || ack) && nxt == 0:
  - valid <= 0; A1/A0 keep their last value; P <= 0.
- A presented request has left P. If its D line reasserts while the code is presented, that counts as a new request and sets P again.
- Repeated requests on the same line coalesce: each line holds 1 pending bit.
- pend_cnt <= popcount(next P), registered in the same edge as P.
- multi:
  - set when popcount(Dv) >= 2.
  - With ERR_STICKY=1, it clears on err_clr; a set in the same cycle as err_clr wins.
  - With ERR_STICKY=0, multi <= (popcount(Dv) >= 2) every cycle, and err_clr is ignored.
- Default priority is fixed: D3 > D2 > D1 > D0.
- Reset values: A1=0, A0=0, valid=0, multi=0, pend_cnt=0, P=0, last=3.

## Timing
- Latency: a D line high before edge k, with the block idle or acking, gives valid and the code after edge k. That is 1 cycle.
- Throughput: with ack held high, one code per cycle; back-to-back codes have no valid gap.
- The code is stable from the edge valid rises until the edge where valid && ack is sampled.
- Simultaneous ack and a new request on the just-presented line: the line is re-queued and, under fixed priority, may be re-presented on the next load.
- Reset mid-operation: all state clears asynchronously as soon as rst_n falls, and pending requests are lost. The first edge after release samples D normally.
- pend_cnt and multi are registered; there is no combinational path from inputs to outputs.

## Configuration
- ENC_RR_EN defined: rotating priority. The search order is (last+1), (last+2), (last+3), (last+4) mod 4, and the first set bit of nxt wins. Because last resets to 3, D0 is served first after reset.
- ENC_RR_EN undefined: fixed priority D3 > D2 > D1 > D0. The last register is not implemented.

## Structure
- Package encoder_pkg holds:
  - NUM_LINES=4, CODE_W=2
  - an onehot(code) function
  - a popcount4 function
- One combinational sub-module, prio_sel4:
  - inputs: req[3:0] and start[1:0]
  - output: sel[1:0]
  - fixed mode ties start to 0 and uses a descending search; rotating mode uses the ascending search from start.
- The top level holds the registers, the load/hold/drain control and the collision logic.

## Test plan
- Reset: rst_n=0 with D=1111 -> A1A0=00, valid=0, pend_cnt=0, multi=0. Release with D=0000 -> valid stays 0.
- Single request: pulse D2 for 1 cycle with ack=1 -> one cycle later valid=1, A1A0=10, pend_cnt=0. The next cycle valid=0 and A1A0 holds 10.
- Burst collision: D=1111 for 1 cycle with ack held 1 -> codes 11, 10, 01, 00 on 4 consecutive cycles; pend_cnt runs 3, 2, 1, 0; multi=1. With ENC_RR_EN the codes are 00, 01, 10, 11.
- Backpressure:
  - Pulse D1 and hold ack=0 for 3 cycles -> A1A0=01 and valid held.
  - Pulse D3 during the hold -> pend_cnt=1.
  - Raise ack -> the next code is 11 and pend_cnt=0.
- Reset mid-operation: with pend_cnt=3 and valid=1, drop rst_n asynchronously -> valid=0 and pend_cnt=0 before the next edge.
- Sticky error with ERR_STICKY=1:
  - Collision, then err_clr together with a new collision -> multi stays 1.
  - err_clr alone -> multi=0.
  - With ERR_STICKY=0, multi pulses for exactly 1 cycle per collision.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared constants and helpers for the 4-to-2 request encoder.
// Holds the line count, code width, one-hot expansion and 4-bit popcount.
package encoder_pkg;

    localparam int NUM_LINES = 4;
    localparam int CODE_W    = 2;

    function automatic logic [NUM_LINES-1:0] onehot(input logic [CODE_W-1:0] code);
        onehot = 4'b0001 << code;
    endfunction

    function automatic logic [2:0] popcount4(input logic [NUM_LINES-1:0] v);
        popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/prio_sel4.sv
// Combinational 4-way priority selector for the encoder queue.
// Default: fixed D3 > D2 > D1 > D0. With ENC_RR_EN: ascending search from start.
module prio_sel4
    import encoder_pkg::*;
(
    input  logic [NUM_LINES-1:0] req,
    input  logic [CODE_W-1:0]    start,
    output logic [CODE_W-1:0]    sel
);

`ifdef ENC_RR_EN
    // Walk from the farthest candidate back to start so the nearest set bit wins.
    always_comb begin
        sel = 2'b00;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            sel = req[start + CODE_W'(i)] ? (start + CODE_W'(i)) : sel;
        end
    end
`else
    logic w_unused;
    assign w_unused = |start;

    // Ascending scan: the highest set index is written last and wins.
    always_comb begin
        sel = 2'b00;
        for (int i = 0; i < NUM_LINES; i++) begin
            sel = req[i] ? CODE_W'(i) : sel;
        end
    end
`endif

endmodule

// File: rtl/encoder4to2_queue.sv
// Registered 4-to-2 priority encoder with per-line pending bits and valid/ack output.
// Optional macro ENC_RR_EN selects rotating priority instead of fixed D3 > D0.
module encoder4to2_queue
    import encoder_pkg::*;
#(
    parameter int ERR_STICKY = 1
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       D0,
    input  logic       D1,
    input  logic       D2,
    input  logic       D3,
    input  logic       ack,
    input  logic       err_clr,
    output logic       A1,
    output logic       A0,
    output logic       valid,
    output logic [2:0] pend_cnt,
    output logic       multi
);

    logic [NUM_LINES-1:0] w_dv;
    logic [NUM_LINES-1:0] w_nxt;
    logic [NUM_LINES-1:0] w_pend_next;
    logic [CODE_W-1:0]    w_sel;
    logic [CODE_W-1:0]    w_start;
    logic                 w_load;
    logic                 w_hold;
    logic                 w_coll;

    logic [NUM_LINES-1:0] r_pend;
    logic [CODE_W-1:0]    r_code;
    logic                 r_valid;
    logic [2:0]           r_pend_cnt;
    logic                 r_multi;

    assign w_dv   = {D3, D2, D1, D0};
    assign w_nxt  = r_pend | w_dv;
    assign w_load = (!r_valid || ack) && (w_nxt != 4'b0000);
    assign w_hold = r_valid && !ack;
    assign w_coll = (popcount4(w_dv) >= 3'd2);

`ifdef ENC_RR_EN
    logic [CODE_W-1:0] r_last;

    // Remember the last granted line so the search starts just after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 2'b11;
        end else if (w_load) begin
            r_last <= w_sel;
        end
    end

    assign w_start = r_last + 2'b01;
`else
    assign w_start = 2'b00;
`endif

    prio_sel4 u_sel (
        .req   (w_nxt),
        .start (w_start),
        .sel   (w_sel)
    );

    // Next pending set: a granted line leaves P, held codes keep accumulating, drain empties.
    always_comb begin
        w_pend_next = 4'b0000;
        if (w_load) begin
            w_pend_next = w_nxt & ~onehot(w_sel);
        end else if (w_hold) begin
            w_pend_next = w_nxt;
        end else begin
            w_pend_next = 4'b0000;
        end
    end

    // Pending bits and their count move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend     <= 4'b0000;
            r_pend_cnt <= 3'd0;
        end else begin
            r_pend     <= w_pend_next;
            r_pend_cnt <= popcount4(w_pend_next);
        end
    end

    // Presented code and valid; the code keeps its last value after a drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code  <= 2'b00;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_code  <= w_sel;
            r_valid <= 1'b1;
        end else if (w_hold) begin
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

    // Collision flag: a new collision beats a simultaneous clear in sticky mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_multi <= 1'b0;
        end else if (ERR_STICKY != 0) begin
            if (w_coll) begin
                r_multi <= 1'b1;
            end else if (err_clr) begin
                r_multi <= 1'b0;
            end
        end else begin
            r_multi <= w_coll;
        end
    end

    assign A1       = r_code[1];
    assign A0       = r_code[0];
    assign valid    = r_valid;
    assign pend_cnt = r_pend_cnt;
    assign multi    = r_multi;

endmodule

// File: tb/tb_encoder4to2_queue.sv
// Self-checking bench for encoder4to2_queue with a scoreboard of expected codes.
// A second instance with ERR_STICKY=0 checks the pulsed collision flag.
module tb_encoder4to2_queue;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       d0 = 1'b0, d1 = 1'b0, d2 = 1'b0, d3 = 1'b0;
    logic       ack = 1'b0;
    logic       err_clr = 1'b0;
    logic       a1, a0, valid, multi;
    logic [2:0] pend_cnt;
    logic       multi0;
    logic       unused_a1, unused_a0, unused_valid;
    logic [2:0] unused_pend;

    int checks = 0;
    int failures = 0;
    logic [1:0] exp_q[$];
    logic [1:0] exp_code;

    encoder4to2_queue #(.ERR_STICKY(1)) dut (
        .clk(clk), .rst_n(rst_n), .D0(d0), .D1(d1), .D2(d2), .D3(d3),
        .ack(ack), .err_clr(err_clr), .A1(a1), .A0(a0), .valid(valid),
        .pend_cnt(pend_cnt), .multi(multi)
    );

    encoder4to2_queue #(.ERR_STICKY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .D0(d0), .D1(d1), .D2(d2), .D3(d3),
        .ack(ack), .err_clr(err_clr), .A1(unused_a1), .A0(unused_a0), .valid(unused_valid),
        .pend_cnt(unused_pend), .multi(multi0)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_d(input logic [3:0] v);
        {d3, d2, d1, d0} = v;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ack = 1'b0; err_clr = 1'b0;
        drive_d(4'b1111);
        tick; tick;
        checks++; if ({a1, a0} !== 2'b00) begin failures++; $display("FAIL reset_code got=%b exp=00", {a1, a0}); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (pend_cnt !== 3'd0) begin failures++; $display("FAIL reset_pend got=%0d exp=0", pend_cnt); end
        checks++; if (multi !== 1'b0) begin failures++; $display("FAIL reset_multi got=%b exp=0", multi); end
        drive_d(4'b0000);
        rst_n = 1'b1;
        tick;
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL release_valid got=%b exp=0", valid); end
    endtask

    task automatic test_single;
        ack = 1'b1;
        drive_d(4'b0100);
        exp_q.push_back(2'b10);
        tick;
        drive_d(4'b0000);
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", valid); end
        checks++; if (pend_cnt !== 3'd0) begin failures++; $display("FAIL single_pend got=%0d exp=0", pend_cnt); end
        checks++; if (multi !== 1'b0) begin failures++; $display("FAIL single_multi got=%b exp=0", multi); end
        if (valid && ack) begin
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("FAIL single_sb got=%b exp=none", {a1, a0}); end
            else begin
                exp_code = exp_q.pop_front();
                if ({a1, a0} !== exp_code) begin failures++; $display("FAIL single_code got=%b exp=%b", {a1, a0}, exp_code); end
            end
        end
        tick;
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", valid); end
        checks++; if ({a1, a0} !== 2'b10) begin failures++; $display("FAIL single_hold_code got=%b exp=10", {a1, a0}); end
    endtask

    task automatic test_burst;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        ack = 1'b1;
        drive_d(4'b1111);
`ifdef ENC_RR_EN
        exp_q.push_back(2'b00); exp_q.push_back(2'b01); exp_q.push_back(2'b10); exp_q.push_back(2'b11);
`else
        exp_q.push_back(2'b11); exp_q.push_back(2'b10); exp_q.push_back(2'b01); exp_q.push_back(2'b00);
`endif
        for (int c = 0; c < 5; c++) begin
            tick;
            drive_d(4'b0000);
            if (c < 4) begin
                checks++; if (valid !== 1'b1) begin failures++; $display("FAIL burst_valid c=%0d got=%b exp=1", c, valid); end
                checks++; if (pend_cnt !== 3'(3 - c)) begin failures++; $display("FAIL burst_pend c=%0d got=%0d exp=%0d", c, pend_cnt, 3 - c); end
                checks++; if (multi !== 1'b1) begin failures++; $display("FAIL burst_multi c=%0d got=%b exp=1", c, multi); end
                if (valid && ack) begin
                    checks++;
                    if (exp_q.size() == 0) begin failures++; $display("FAIL burst_sb c=%0d got=%b exp=none", c, {a1, a0}); end
                    else begin
                        exp_code = exp_q.pop_front();
                        if ({a1, a0} !== exp_code) begin failures++; $display("FAIL burst_code c=%0d got=%b exp=%b", c, {a1, a0}, exp_code); end
                    end
                end
            end else begin
                checks++; if (valid !== 1'b0) begin failures++; $display("FAIL burst_end_valid got=%b exp=0", valid); end
            end
            if (c < 2) begin
                checks++; if (multi0 !== (c == 0)) begin failures++; $display("FAIL burst_pulse c=%0d got=%b exp=%b", c, multi0, c == 0); end
            end
        end
    endtask

    task automatic test_backpressure;
        ack = 1'b0;
        drive_d(4'b0010);
        exp_q.push_back(2'b01);
        for (int c = 0; c < 3; c++) begin
            tick;
            drive_d((c == 1) ? 4'b1000 : 4'b0000);
            checks++; if (valid !== 1'b1) begin failures++; $display("FAIL bp_valid c=%0d got=%b exp=1", c, valid); end
            checks++; if ({a1, a0} !== 2'b01) begin failures++; $display("FAIL bp_code c=%0d got=%b exp=01", c, {a1, a0}); end
        end
        checks++; if (pend_cnt !== 3'd1) begin failures++; $display("FAIL bp_pend got=%0d exp=1", pend_cnt); end
        exp_q.push_back(2'b11);
        ack = 1'b1;
        for (int c = 0; c < 2; c++) begin
            if (valid && ack) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL bp_sb c=%0d got=%b exp=none", c, {a1, a0}); end
                else begin
                    exp_code = exp_q.pop_front();
                    if ({a1, a0} !== exp_code) begin failures++; $display("FAIL bp_code_ack c=%0d got=%b exp=%b", c, {a1, a0}, exp_code); end
                end
            end
            tick;
        end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", valid); end
    endtask

    task automatic test_reset_mid;
        ack = 1'b0;
        drive_d(4'b1111);
        tick;
        drive_d(4'b0000);
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%b exp=1", valid); end
        checks++; if (pend_cnt !== 3'd3) begin failures++; $display("FAIL mid_pre_pend got=%0d exp=3", pend_cnt); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", valid); end
        checks++; if (pend_cnt !== 3'd0) begin failures++; $display("FAIL mid_pend got=%0d exp=0", pend_cnt); end
        checks++; if (multi !== 1'b0) begin failures++; $display("FAIL mid_multi got=%b exp=0", multi); end
        tick;
        rst_n = 1'b1;
    endtask

    task automatic test_sticky;
        logic [3:0] dpat [4];
        logic       clr  [4];
        dpat[0] = 4'b0011; dpat[1] = 4'b0000; dpat[2] = 4'b1100; dpat[3] = 4'b0000;
        clr[0]  = 1'b0;    clr[1]  = 1'b0;    clr[2]  = 1'b1;    clr[3]  = 1'b0;
        ack = 1'b1;
`ifdef ENC_RR_EN
        exp_q.push_back(2'b00); exp_q.push_back(2'b01); exp_q.push_back(2'b10); exp_q.push_back(2'b11);
`else
        exp_q.push_back(2'b01); exp_q.push_back(2'b00); exp_q.push_back(2'b11); exp_q.push_back(2'b10);
`endif
        for (int c = 0; c < 4; c++) begin
            drive_d(dpat[c]);
            err_clr = clr[c];
            tick;
            checks++; if (multi !== 1'b1) begin failures++; $display("FAIL sticky_multi c=%0d got=%b exp=1", c, multi); end
            checks++; if (multi0 !== ((c % 2) == 0)) begin failures++; $display("FAIL pulse_multi c=%0d got=%b exp=%b", c, multi0, (c % 2) == 0); end
            if (valid && ack) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL sticky_sb c=%0d got=%b exp=none", c, {a1, a0}); end
                else begin
                    exp_code = exp_q.pop_front();
                    if ({a1, a0} !== exp_code) begin failures++; $display("FAIL sticky_code c=%0d got=%b exp=%b", c, {a1, a0}, exp_code); end
                end
            end
        end
        drive_d(4'b0000);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        checks++; if (multi !== 1'b0) begin failures++; $display("FAIL clr_multi got=%b exp=0", multi); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL clr_valid got=%b exp=0", valid); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_burst;
        test_backpressure;
        test_reset_mid;
        test_sticky;
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
